// File: rtl/fpu_unpack.sv
`default_nettype none
// =============================================================================
// fpu_unpack: binary32 operand decoder with iterative subnormal normalization.
// Revision: 1.0
// =============================================================================
module fpu_unpack #(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sign,
   output logic [9:0]  out_exponent,
   output logic [23:0] out_mantissa,
   output logic [2:0]  out_guard,
   output logic [1:0]  out_mode,
   output logic        out_nan,
   output logic        out_snan,
   output logic        out_inf,
   output logic        out_zero,
   output logic        out_subnormal,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_NORM = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [4:0] STEP    = 5'(SHIFT_STEP);

   logic [1:0]  state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic        sign_q, sign_d;
   logic [9:0]  exp_q, exp_d;
   logic [23:0] mant_q, mant_d;
   logic [1:0]  mode_q, mode_d;
   logic        nan_q, nan_d;
   logic        snan_q, snan_d;
   logic        inf_q, inf_d;
   logic        zero_q, zero_d;
   logic        sub_q, sub_d;

   logic        ready_int;
   logic        accept;
   logic [7:0]  in_exp;
   logic [22:0] in_frac;
   logic [4:0]  lz;
   logic [4:0]  shamt;
   logic [23:0] mant_shl;

   function automatic logic [4:0] count_lz(input logic [23:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd0;
      found = 1'b0;
      for (int i = 23; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n     = n + 5'd1;
         end
      end
      return n;
   endfunction

   assign in_exp  = in_data[30:23];
   assign in_frac = in_data[22:0];

   // A new operand may enter whenever no normalization is running and the
   // output slot is empty or being drained this cycle.
   assign ready_int = (state_q != ST_NORM) && (!out_valid_q || out_ready);
   assign accept    = in_valid && ready_int;

   assign lz       = count_lz(mant_q);
   assign shamt    = (lz < STEP) ? lz : STEP;
   assign mant_shl = mant_q << shamt;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         sign_q      <= 1'b0;
         exp_q       <= 10'd0;
         mant_q      <= 24'd0;
         mode_q      <= 2'd0;
         nan_q       <= 1'b0;
         snan_q      <= 1'b0;
         inf_q       <= 1'b0;
         zero_q      <= 1'b0;
         sub_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         mant_q      <= mant_d;
         mode_q      <= mode_d;
         nan_q       <= nan_d;
         snan_q      <= snan_d;
         inf_q       <= inf_d;
         zero_q      <= zero_d;
         sub_q       <= sub_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      mant_d      = mant_q;
      mode_d      = mode_q;
      nan_d       = nan_q;
      snan_d      = snan_q;
      inf_d       = inf_q;
      zero_d      = zero_q;
      sub_d       = sub_q;

      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
            if (accept) begin
               sign_d      = in_data[31];
               mode_d      = in_mode;
               nan_d       = 1'b0;
               snan_d      = 1'b0;
               inf_d       = 1'b0;
               zero_d      = 1'b0;
               sub_d       = 1'b0;
               state_d     = ST_HOLD;
               out_valid_d = 1'b1;
               if (in_exp == 8'hFF) begin
                  exp_d = 10'd255;
                  if (in_frac != 23'd0) begin
                     nan_d  = 1'b1;
                     snan_d = !in_frac[22];
                     mant_d = {1'b1, in_frac};
                  end else begin
                     inf_d  = 1'b1;
                     mant_d = 24'h800000;
                  end
               end else if (in_exp == 8'h00) begin
                  if (in_frac == 23'd0) begin
                     zero_d = 1'b1;
                     mant_d = 24'd0;
                     exp_d  = 10'd0;
                  end else begin
                     sub_d       = 1'b1;
                     mant_d      = {1'b0, in_frac};
                     exp_d       = 10'd1;
                     state_d     = ST_NORM;
                     out_valid_d = 1'b0;
                  end
               end else begin
                  mant_d = {1'b1, in_frac};
                  exp_d  = {2'b00, in_exp};
               end
            end
         end
         ST_NORM: begin
            // Shift by at most STEP; result is published the cycle bit 23 lands.
            mant_d = mant_shl;
            exp_d  = exp_q - {5'd0, shamt};
            if (mant_shl[23]) begin
               state_d     = ST_HOLD;
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Outputs
   always_comb begin
      in_ready      = ready_int && !rst;
      out_valid     = out_valid_q;
      out_sign      = sign_q;
      out_exponent  = exp_q;
      out_mantissa  = mant_q;
      out_guard     = 3'b000;
      out_mode      = mode_q;
      out_nan       = nan_q;
      out_snan      = snan_q;
      out_inf       = inf_q;
      out_zero      = zero_q;
      out_subnormal = sub_q;
      busy          = (state_q != ST_IDLE) || out_valid_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_fpu_unpack.sv
`default_nettype none
// =============================================================================
// tb_fpu_unpack: directed bench for fpu_unpack at SHIFT_STEP 1, 4 and 8.
// Revision: 1.0
// =============================================================================
module tb_fpu_unpack;

   logic        clk;
   logic        rst;
   logic        in_valid_a  [3];
   logic [31:0] in_data_a   [3];
   logic [1:0]  in_mode_a   [3];
   logic        out_ready_a [3];
   wire         in_ready_a  [3];
   wire         out_valid_a [3];
   wire         out_sign_a  [3];
   wire  [9:0]  out_exp_a   [3];
   wire  [23:0] out_mant_a  [3];
   wire  [2:0]  out_guard_a [3];
   wire  [1:0]  out_mode_a  [3];
   wire         out_nan_a   [3];
   wire         out_snan_a  [3];
   wire         out_inf_a   [3];
   wire         out_zero_a  [3];
   wire         out_sub_a   [3];
   wire         busy_a      [3];

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int STEP = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
      fpu_unpack #(.SHIFT_STEP(STEP)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .in_valid     (in_valid_a[g]),
         .in_ready     (in_ready_a[g]),
         .in_data      (in_data_a[g]),
         .in_mode      (in_mode_a[g]),
         .out_valid    (out_valid_a[g]),
         .out_ready    (out_ready_a[g]),
         .out_sign     (out_sign_a[g]),
         .out_exponent (out_exp_a[g]),
         .out_mantissa (out_mant_a[g]),
         .out_guard    (out_guard_a[g]),
         .out_mode     (out_mode_a[g]),
         .out_nan      (out_nan_a[g]),
         .out_snan     (out_snan_a[g]),
         .out_inf      (out_inf_a[g]),
         .out_zero     (out_zero_a[g]),
         .out_subnormal(out_sub_a[g]),
         .busy         (busy_a[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // flags order: {nan, snan, inf, zero, subnormal}
   task automatic check_res(input int k, input string tag, input logic s,
                            input logic [9:0] e, input logic [23:0] m,
                            input logic [4:0] fl, input logic [1:0] md);
      chk({tag, ".valid"}, 32'(out_valid_a[k]), 32'd1);
      chk({tag, ".sign"},  32'(out_sign_a[k]),  32'(s));
      chk({tag, ".exp"},   32'(out_exp_a[k]),   32'(e));
      chk({tag, ".mant"},  32'(out_mant_a[k]),  32'(m));
      chk({tag, ".guard"}, 32'(out_guard_a[k]), 32'd0);
      chk({tag, ".mode"},  32'(out_mode_a[k]),  32'(md));
      chk({tag, ".flags"}, 32'({out_nan_a[k], out_snan_a[k], out_inf_a[k],
                                out_zero_a[k], out_sub_a[k]}), 32'(fl));
   endtask

   // Called #1 after a clock edge; returns with the result visible.
   task automatic run_op(input int k, input logic [31:0] d, input logic [1:0] md,
                         input int want_lat, input string tag);
      int n;
      int lat;
      in_data_a[k]  = d;
      in_mode_a[k]  = md;
      in_valid_a[k] = 1'b1;
      n = 0;
      while (!in_ready_a[k] && n < 50) begin
         step();
         n++;
      end
      chk({tag, ".ready"}, 32'(in_ready_a[k]), 32'd1);
      step();
      in_valid_a[k] = 1'b0;
      lat = 1;
      while (!out_valid_a[k] && lat < 60) begin
         step();
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(want_lat));
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid_a[i]  = 1'b0;
         in_data_a[i]   = 32'd0;
         in_mode_a[i]   = 2'd0;
         out_ready_a[i] = 1'b1;
      end
      #3;
      chk("rst.in_ready",  32'(in_ready_a[0]),  32'd0);
      chk("rst.out_valid", 32'(out_valid_a[0]), 32'd0);
      chk("rst.busy",      32'(busy_a[0]),      32'd0);
      chk("rst.exp",       32'(out_exp_a[0]),   32'd0);
      chk("rst.mant",      32'(out_mant_a[0]),  32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // normal 1.0
      run_op(0, 32'h3F800000, 2'b00, 1, "one");
      check_res(0, "one", 1'b0, 10'd127, 24'h800000, 5'b00000, 2'b00);
      step();
      chk("one.drain", 32'(out_valid_a[0]), 32'd0);

      // smallest subnormal at steps 1 and 8
      run_op(0, 32'h00000001, 2'b01, 24, "sub1s1");
      check_res(0, "sub1s1", 1'b0, 10'h3EA, 24'h800000, 5'b00001, 2'b01);
      step();
      run_op(2, 32'h00000001, 2'b11, 4, "sub1s8");
      check_res(2, "sub1s8", 1'b0, 10'h3EA, 24'h800000, 5'b00001, 2'b11);
      step();

      // specials
      run_op(0, 32'hFF800000, 2'b10, 1, "ninf");
      check_res(0, "ninf", 1'b1, 10'd255, 24'h800000, 5'b00100, 2'b10);
      step();
      run_op(0, 32'h7FC00000, 2'b00, 1, "qnan");
      check_res(0, "qnan", 1'b0, 10'd255, 24'hC00000, 5'b10000, 2'b00);
      step();
      run_op(0, 32'h7F800001, 2'b00, 1, "snan");
      check_res(0, "snan", 1'b0, 10'd255, 24'h800001, 5'b11000, 2'b00);
      step();
      run_op(0, 32'h80000000, 2'b01, 1, "nzero");
      check_res(0, "nzero", 1'b1, 10'd0, 24'h000000, 5'b00010, 2'b01);
      step();

      // subnormal boundaries
      run_op(0, 32'h00400000, 2'b00, 2, "sublz1");
      check_res(0, "sublz1", 1'b0, 10'd0, 24'h800000, 5'b00001, 2'b00);
      step();
      run_op(1, 32'h00000003, 2'b00, 7, "sub3s4");
      check_res(1, "sub3s4", 1'b0, 10'h3EB, 24'hC00000, 5'b00001, 2'b00);
      step();

      // back-to-back with full throughput, then backpressure
      in_mode_a[0]  = 2'b01;
      in_data_a[0]  = 32'h3F800000;
      in_valid_a[0] = 1'b1;
      step();
      chk("b2b.a.valid", 32'(out_valid_a[0]), 32'd1);
      chk("b2b.a.exp",   32'(out_exp_a[0]),   32'd127);
      chk("b2b.a.ready", 32'(in_ready_a[0]),  32'd1);
      in_data_a[0] = 32'h40000000;
      step();
      chk("b2b.b.valid", 32'(out_valid_a[0]), 32'd1);
      chk("b2b.b.exp",   32'(out_exp_a[0]),   32'd128);
      in_data_a[0] = 32'h40800000;
      step();
      chk("b2b.c.exp",   32'(out_exp_a[0]),   32'd129);
      out_ready_a[0] = 1'b0;
      in_data_a[0]   = 32'h41000000;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp.ready", 32'(in_ready_a[0]),  32'd0);
         step();
         chk("bp.valid", 32'(out_valid_a[0]), 32'd1);
         chk("bp.exp",   32'(out_exp_a[0]),   32'd129);
         chk("bp.mant",  32'(out_mant_a[0]),  32'h800000);
      end
      out_ready_a[0] = 1'b1;
      #1;
      chk("rel.ready", 32'(in_ready_a[0]), 32'd1);
      step();
      in_valid_a[0] = 1'b0;
      chk("rel.d.valid", 32'(out_valid_a[0]), 32'd1);
      chk("rel.d.exp",   32'(out_exp_a[0]),   32'd130);
      step();
      chk("rel.idle.valid", 32'(out_valid_a[0]), 32'd0);
      chk("rel.idle.busy",  32'(busy_a[0]),      32'd0);

      // reset in the middle of normalization
      in_data_a[0]  = 32'h00000001;
      in_mode_a[0]  = 2'b00;
      in_valid_a[0] = 1'b1;
      step();
      in_valid_a[0] = 1'b0;
      step();
      step();
      chk("norm.valid", 32'(out_valid_a[0]), 32'd0);
      chk("norm.busy",  32'(busy_a[0]),      32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst.valid", 32'(out_valid_a[0]), 32'd0);
      chk("midrst.busy",  32'(busy_a[0]),      32'd0);
      chk("midrst.ready", 32'(in_ready_a[0]),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      run_op(0, 32'h40000000, 2'b10, 1, "two");
      check_res(0, "two", 1'b0, 10'd128, 24'h800000, 5'b00000, 2'b10);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
